// File: rtl/arb_pkg.sv
// Shared encodings for the one-hot bus arbiter: state bit indices, one-hot
// state constants and owner codes.
package arb_pkg;

  localparam int STATE_W = 6;

  localparam int IDLE   = 0;
  localparam int CYCLEA = 1;
  localparam int CYCLEC = 2;
  localparam int MSTRA  = 3;
  localparam int MSTRB  = 4;
  localparam int MSTRC  = 5;

  localparam logic [STATE_W-1:0] S_IDLE   = 6'b000001;
  localparam logic [STATE_W-1:0] S_CYCLEA = 6'b000010;
  localparam logic [STATE_W-1:0] S_CYCLEC = 6'b000100;

  localparam logic [1:0] OWN_A    = 2'd0;
  localparam logic [1:0] OWN_B    = 2'd1;
  localparam logic [1:0] OWN_C    = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three active-high requests; the search
// starts at the master after 'last'.
module rr_pick3
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win,
  output logic       any
);

  always_comb begin
    win = 3'b000;
    any = |req;
    case (last)
      OWN_A:   win = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      OWN_B:   win = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: win = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
  end

endmodule

// File: rtl/onehot_bus_arbiter.sv
// Registered one-hot arbiter sharing one bus among masters A/B/C; each tenure
// runs arbitrate (CYCLEC), grant (MSTRx), turnaround (CYCLEA).
module onehot_bus_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nREQA,
  input  logic               nREQB,
  input  logic               nREQC,
  input  logic               done,
  output logic [2:0]         gnt_n,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         owner,
  output logic               timeout
);

  localparam bit               LIMIT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LIMIT_EN ? MAX_HOLD - 1 : 0);

  logic [STATE_W-1:0] r_state;
  logic [2:0]         r_gnt_n;
  logic [1:0]         r_owner;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_last;

  logic [2:0]         w_req;
  logic [2:0]         w_win;
  logic               w_any;
  logic               w_onehot;
  logic               w_inMstr;
  logic               w_ownReq;
  logic               w_others;
  logic               w_limit;
  logic               w_exit;
  logic [STATE_W-1:0] w_next;

  assign w_req = ~{nREQC, nREQB, nREQA};

  rr_pick3 u_pick (
    .req  (w_req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  assign w_onehot = (r_state != '0) && ((r_state & (r_state - 1'b1)) == '0);
  assign w_inMstr = |r_state[MSTRC:MSTRA];
  assign w_ownReq = (r_state[MSTRA] & w_req[0]) | (r_state[MSTRB] & w_req[1])
                  | (r_state[MSTRC] & w_req[2]);
  assign w_others = (r_state[MSTRA] & (w_req[1] | w_req[2]))
                  | (r_state[MSTRB] & (w_req[0] | w_req[2]))
                  | (r_state[MSTRC] & (w_req[0] | w_req[1]));
  assign w_limit  = LIMIT_EN && (r_count == LIMIT) && w_others;
  assign w_exit   = w_onehot && w_inMstr && (done || !w_ownReq || w_limit);

  // The winner vector lines up with the MSTRA..MSTRC bits, so it drops straight in.
  always_comb begin
    w_next = S_IDLE;
    if (w_onehot) begin
      if (r_state[IDLE] || r_state[CYCLEA]) begin
        w_next = w_any ? S_CYCLEC : S_IDLE;
      end else if (r_state[CYCLEC]) begin
        w_next = w_any ? {w_win, 3'b000} : S_IDLE;
      end else begin
        w_next = w_exit ? S_CYCLEA : r_state;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt_n   <= 3'b111;
      r_owner   <= OWN_NONE;
      r_timeout <= 1'b0;
      r_count   <= '0;
      r_last    <= OWN_C;
    end else begin
      r_state   <= w_next;
      r_gnt_n   <= ~w_next[MSTRC:MSTRA];
      r_owner   <= w_next[MSTRA] ? OWN_A :
                   w_next[MSTRB] ? OWN_B :
                   w_next[MSTRC] ? OWN_C : OWN_NONE;
      r_timeout <= w_exit && w_limit && !done && w_ownReq;
      if (!w_inMstr) begin
        r_count <= '0;
      end else if (r_count != '1) begin
        r_count <= r_count + 1'b1;
      end
      if (w_exit) begin
        r_last <= r_owner;
      end
    end
  end

  assign gnt_n   = r_gnt_n;
  assign state   = r_state;
  assign owner   = r_owner;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_onehot_bus_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=0) share stimulus
// and are compared every cycle against a tenure-level model.
module tb_onehot_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nREQA, nREQB, nREQC, done;
  logic [2:0] gnt4, gnt0;
  logic [5:0] st4, st0;
  logic [1:0] own4, own0;
  logic       to4, to0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  onehot_bus_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .nREQA(nREQA), .nREQB(nREQB), .nREQC(nREQC),
    .done(done), .gnt_n(gnt4), .state(st4), .owner(own4), .timeout(to4)
  );

  onehot_bus_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .nREQA(nREQA), .nREQB(nREQB), .nREQC(nREQC),
    .done(done), .gnt_n(gnt0), .state(st0), .owner(own0), .timeout(to0)
  );

  localparam int PH_IDLE = 0, PH_ARB = 1, PH_GRANT = 2, PH_TURN = 3;

  // Tenure-level model: phase, current owner, last owner, cycles granted so far.
  typedef struct {
    int phase;
    int cur;
    int last;
    int held;
    bit tout;
  } model_t;

  model_t m4, m0;

  function automatic model_t modelReset();
    model_t r;
    r.phase = PH_IDLE;
    r.cur   = 0;
    r.last  = 2;
    r.held  = 0;
    r.tout  = 1'b0;
    return r;
  endfunction

  function automatic model_t modelNext(model_t m, logic [2:0] req, logic dn, int maxHold);
    model_t n;
    bit others, limit, found;
    n = m;
    n.tout = 1'b0;
    case (m.phase)
      PH_IDLE: if (req != 3'b000) n.phase = PH_ARB;
      PH_ARB: begin
        n.phase = PH_IDLE;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m.last + k) % 3;
          if (!found && req[c]) begin
            found   = 1'b1;
            n.phase = PH_GRANT;
            n.cur   = c;
            n.held  = 0;
          end
        end
      end
      PH_GRANT: begin
        others = 1'b0;
        for (int k = 0; k < 3; k++) if (k != m.cur && req[k]) others = 1'b1;
        limit = (maxHold != 0) && (m.held == maxHold - 1) && others;
        if (dn || !req[m.cur] || limit) begin
          n.phase = PH_TURN;
          n.last  = m.cur;
          n.tout  = limit && !dn && req[m.cur];
        end else begin
          n.held = m.held + 1;
        end
      end
      default: n.phase = (req != 3'b000) ? PH_ARB : PH_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] expGnt(model_t m);
    return (m.phase == PH_GRANT) ? ~(3'b001 << m.cur) : 3'b111;
  endfunction

  function automatic logic [5:0] expState(model_t m);
    case (m.phase)
      PH_IDLE:  return 6'b000001;
      PH_TURN:  return 6'b000010;
      PH_ARB:   return 6'b000100;
      default:  return 6'b001000 << m.cur;
    endcase
  endfunction

  function automatic logic [1:0] expOwner(model_t m);
    return (m.phase == PH_GRANT) ? 2'(m.cur) : 2'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= modelReset();
      m0 <= modelReset();
    end else begin
      m4 <= modelNext(m4, ~{nREQC, nREQB, nREQA}, done, 4);
      m0 <= modelNext(m0, ~{nREQC, nREQB, nREQA}, done, 0);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every cycle, away from the rising edge, both DUTs must agree with the model.
  always @(negedge clk) begin
    checkOutput("model gnt4",  int'(gnt4), int'(expGnt(m4)));
    checkOutput("model st4",   int'(st4),  int'(expState(m4)));
    checkOutput("model own4",  int'(own4), int'(expOwner(m4)));
    checkOutput("model to4",   int'(to4),  int'(m4.tout));
    checkOutput("model gnt0",  int'(gnt0), int'(expGnt(m0)));
    checkOutput("model st0",   int'(st0),  int'(expState(m0)));
    checkOutput("model own0",  int'(own0), int'(expOwner(m0)));
    checkOutput("model to0",   int'(to0),  int'(m0.tout));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic c, input logic d);
    nREQA = a;
    nREQB = b;
    nREQC = c;
    done  = d;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expOrder[4];
    int gi, gcyc, dead, prevOwner, aCycles, bad;
    bit seenA;
    expOrder = '{0, 1, 2, 0};

    rst_n = 1'b0;
    resetDut();
    checkOutput("reset gnt_n",   int'(gnt4), 7);
    checkOutput("reset state",   int'(st4),  1);
    checkOutput("reset owner",   int'(own4), 3);
    checkOutput("reset timeout", int'(to4),  0);

    // Single request from A, closed by done.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("A grant gnt_n", int'(gnt4), 6);
    checkOutput("A grant owner", int'(own4), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("A turn gnt_n", int'(gnt4), 7);
    checkOutput("A turn state", int'(st4),  2);
    done = 1'b0;
    tick();
    checkOutput("A back idle", int'(st4), 1);

    // All three requesting, done on every third grant cycle.
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    gi = 0; gcyc = 0; dead = 0; prevOwner = 3;
    for (int cyc = 0; cyc < 60 && gi < 4; cyc++) begin
      tick();
      if (own4 != 2'd3) begin
        if (prevOwner == 3) begin
          if (gi > 0) checkOutput("rr dead cycles", dead, 2);
          checkOutput("rr grant order", int'(own4), expOrder[gi]);
          gi++;
          gcyc = 0;
        end
        gcyc++;
        dead = 0;
        done = (gcyc == 3);
      end else begin
        dead++;
        done = 1'b0;
      end
      prevOwner = int'(own4);
    end
    done = 1'b0;
    checkOutput("rr grant count", gi, 4);

    // A and B low, A never says done: hold limit hands over to B on dut4.
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    aCycles = 0; seenA = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (own4 == 2'd0) begin
        aCycles++;
        seenA = 1'b1;
      end else if (seenA) begin
        break;
      end
    end
    checkOutput("limit hold cycles", aCycles, 4);
    checkOutput("limit timeout",     int'(to4),  1);
    checkOutput("limit turn gnt_n",  int'(gnt4), 7);
    tick();
    checkOutput("limit timeout clr", int'(to4),  0);
    tick();
    checkOutput("limit owner B",     int'(own4), 1);

    // Same traffic on dut0 keeps A granted forever, past counter saturation.
    bad = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (own0 !== 2'd0 || to0 !== 1'b0) bad++;
    end
    checkOutput("nolimit violations", bad, 0);
    checkOutput("nolimit owner A",    int'(own0), 0);

    // done coincides with the hold limit: no timeout pulse.
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    aCycles = 0; seenA = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (own4 == 2'd0) begin
        aCycles++;
        seenA = 1'b1;
        done = (aCycles == 4);
      end else if (seenA) begin
        break;
      end
    end
    done = 1'b0;
    checkOutput("done+limit cycles",  aCycles, 4);
    checkOutput("done+limit timeout", int'(to4), 0);
    checkOutput("done+limit state",   int'(st4), 2);
    tick();
    checkOutput("done+limit to clr",  int'(to4), 0);
    tick();
    checkOutput("done+limit owner B", int'(own4), 1);

    // Asynchronous reset in the middle of B's tenure.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("pre-reset owner B", int'(own4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst gnt_n", int'(gnt4), 7);
    checkOutput("async rst state", int'(st4),  1);
    checkOutput("async rst owner", int'(own4), 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("post-reset owner C", int'(own4), 2);
    checkOutput("post-reset gnt_n",   int'(gnt4), 3);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
